// File: rtl/btn_sequence_reader.sv
`default_nettype none
// =============================================================================
// btn_sequence_reader: sync + debounce 3 buttons, emit press events, check order 0->1->2.
// Optional inter-press timeout compiled in with `BTN_SEQ_TIMEOUT_EN.  Rev 1.0
// =============================================================================
module btn_sequence_reader #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned TIMEOUT_CYCLES  = 200000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] btn,
  output logic [2:0] press_pulse,
  output logic       press_valid,
  output logic [1:0] press_code,
  output logic [1:0] stage,
  output logic       seq_ok,
  output logic       seq_err
);

  localparam logic [31:0] c_db_last = 32'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GOT0 = 2'd1,
    GOT1 = 2'd2
  } state_t;

  logic [2:0] r_sync1;
  logic [2:0] r_sync2;
  logic [2:0] w_stable;
  logic [2:0] r_stable_d;
  logic [2:0] w_rise;
  logic [1:0] w_code;
  state_t     r_state;
  state_t     w_press_next;
  logic       w_press_ok;
  logic       w_press_err;

  if (DEBOUNCE_CYCLES < 2 || TIMEOUT_CYCLES < 2) begin : g_bad_param
    $error("btn_sequence_reader: DEBOUNCE_CYCLES and TIMEOUT_CYCLES must be >= 2");
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= btn;
      r_sync2 <= r_sync1;
    end
  end

  for (genvar i = 0; i < 3; i++) begin : g_debounce
    logic [31:0] r_cnt;
    logic        r_stb;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_cnt <= '0;
        r_stb <= 1'b0;
      end else if (r_sync2[i] == r_stb) begin
        r_cnt <= '0;
      end else if (r_cnt == c_db_last) begin
        r_stb <= r_sync2[i];
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 32'd1;
      end
    end

    assign w_stable[i] = r_stb;
  end

  assign w_rise = w_stable & ~r_stable_d;

  always_comb begin
    w_code = 2'd0;
    if (w_rise[0])      w_code = 2'd0;
    else if (w_rise[1]) w_code = 2'd1;
    else if (w_rise[2]) w_code = 2'd2;
  end

  // Edge detect against the previous stable value adds the one registered cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stable_d  <= '0;
      press_pulse <= '0;
      press_valid <= 1'b0;
      press_code  <= '0;
    end else begin
      r_stable_d  <= w_stable;
      press_pulse <= w_rise;
      press_valid <= |w_rise;
      press_code  <= w_code;
    end
  end

  // Verdict for a press in the current state; only an exact one-hot match advances.
  always_comb begin
    w_press_next = IDLE;
    w_press_ok   = 1'b0;
    w_press_err  = 1'b0;
    case (r_state)
      IDLE:    if (press_pulse == 3'b001) w_press_next = GOT0; else w_press_err = 1'b1;
      GOT0:    if (press_pulse == 3'b010) w_press_next = GOT1; else w_press_err = 1'b1;
      GOT1:    if (press_pulse == 3'b100) w_press_ok = 1'b1;   else w_press_err = 1'b1;
      default: w_press_next = IDLE;
    endcase
  end

`ifdef BTN_SEQ_TIMEOUT_EN
  localparam logic [31:0] c_to_last = 32'(TIMEOUT_CYCLES - 1);
  logic [31:0] r_timer;

  // Timeout has priority over a coincident press, which is then dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_timer <= '0;
      seq_ok  <= 1'b0;
      seq_err <= 1'b0;
    end else begin
      seq_ok  <= 1'b0;
      seq_err <= 1'b0;
      if (r_state != IDLE && r_timer == c_to_last) begin
        seq_err <= 1'b1;
        r_state <= IDLE;
        r_timer <= '0;
      end else if (press_valid) begin
        r_state <= w_press_next;
        seq_ok  <= w_press_ok;
        seq_err <= w_press_err;
        r_timer <= '0;
      end else if (r_state != IDLE) begin
        r_timer <= r_timer + 32'd1;
      end else begin
        r_timer <= '0;
      end
    end
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      seq_ok  <= 1'b0;
      seq_err <= 1'b0;
    end else begin
      seq_ok  <= 1'b0;
      seq_err <= 1'b0;
      if (press_valid) begin
        r_state <= w_press_next;
        seq_ok  <= w_press_ok;
        seq_err <= w_press_err;
      end
    end
  end
`endif

  assign stage = r_state;

endmodule
`default_nettype wire

// File: tb/tb_btn_sequence_reader.sv
`default_nettype none
// =============================================================================
// tb_btn_sequence_reader: directed table-driven bench, DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=50.
// Rev 1.0
// =============================================================================
module tb_btn_sequence_reader;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] btn;
  logic [2:0] press_pulse;
  logic       press_valid;
  logic [1:0] press_code;
  logic [1:0] stage;
  logic       seq_ok;
  logic       seq_err;
  logic [9:0] outs;

  int n_vec  = 0;
  int n_fail = 0;
  int ok_cnt = 0;
  int err_cnt = 0;

  typedef struct {
    logic [2:0] pattern;
    logic [2:0] pulse;
    int         code;
    int         stage;
    int         ok;
    int         err;
  } step_t;

  step_t steps[15];

  btn_sequence_reader #(
    .DEBOUNCE_CYCLES(4),
    .TIMEOUT_CYCLES (50)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn        (btn),
    .press_pulse(press_pulse),
    .press_valid(press_valid),
    .press_code (press_code),
    .stage      (stage),
    .seq_ok     (seq_ok),
    .seq_err    (seq_err)
  );

  always #5 clk = ~clk;

  assign outs = {press_pulse, press_valid, press_code, stage, seq_ok, seq_err};

  always @(negedge clk) begin
    if (seq_ok)  ok_cnt++;
    if (seq_err) err_cnt++;
  end

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Negedges until press_valid shows, 99 if it never does.
  task automatic wait_press(output int lat);
    lat = 99;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      if (press_valid) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic run_step(input int idx, input step_t s);
    int lat;
    int ok0;
    int err0;
    ok0  = ok_cnt;
    err0 = err_cnt;
    btn  = s.pattern;
    wait_press(lat);
    check($sformatf("step%0d latency", idx), lat, 7);
    check($sformatf("step%0d press_valid", idx), int'(press_valid), 1);
    check($sformatf("step%0d press_pulse", idx), int'(press_pulse), int'(s.pulse));
    check($sformatf("step%0d press_code", idx), int'(press_code), s.code);
    @(negedge clk);
    check($sformatf("step%0d stage", idx), int'(stage), s.stage);
    repeat (2) @(negedge clk);
    btn = 3'b000;
    repeat (20) @(negedge clk);
    check($sformatf("step%0d seq_ok pulses", idx), ok_cnt - ok0, s.ok);
    check($sformatf("step%0d seq_err pulses", idx), err_cnt - err0, s.err);
  endtask

  initial begin
    int lat;
    int first;
    int hits;
    int stg_at;
    int early;

    //               pattern  pulse   code stage ok err
    steps[0]  = '{3'b001, 3'b001, 0, 1, 0, 0};  // good sequence
    steps[1]  = '{3'b010, 3'b010, 1, 2, 0, 0};
    steps[2]  = '{3'b100, 3'b100, 2, 0, 1, 0};
    steps[3]  = '{3'b001, 3'b001, 0, 1, 0, 0};  // wrong order
    steps[4]  = '{3'b100, 3'b100, 2, 0, 0, 1};
    steps[5]  = '{3'b001, 3'b001, 0, 1, 0, 0};  // simultaneous 1+2
    steps[6]  = '{3'b110, 3'b110, 1, 0, 0, 1};
    steps[7]  = '{3'b010, 3'b010, 1, 0, 0, 1};  // wrong start from IDLE
    steps[8]  = '{3'b001, 3'b001, 0, 1, 0, 0};  // repeated 0 is an error, not a restart
    steps[9]  = '{3'b001, 3'b001, 0, 0, 0, 1};
    steps[10] = '{3'b001, 3'b001, 0, 1, 0, 0};  // repeated 1 from GOT1
    steps[11] = '{3'b010, 3'b010, 1, 2, 0, 0};
    steps[12] = '{3'b010, 3'b010, 1, 0, 0, 1};
    steps[13] = '{3'b001, 3'b001, 0, 1, 0, 0};  // set up reset mid-sequence
    steps[14] = '{3'b010, 3'b010, 1, 2, 0, 0};

    rst = 1'b1;
    btn = 3'b000;
    repeat (3) @(negedge clk);
    check("reset outputs", int'(outs), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Bounce on button 0: toggle every 2 cycles, then a clean rising edge.
    early = 0;
    for (int i = 0; i < 20; i++) begin
      btn[0] = ((i / 2) % 2) == 0;
      @(negedge clk);
      if (press_valid) early++;
    end
    btn[0] = 1'b1;
    wait_press(lat);
    check("bounce no early pulse", early, 0);
    check("bounce latency", lat, 7);
    check("bounce press_pulse", int'(press_pulse), 1);
    check("bounce press_code", int'(press_code), 0);
    @(negedge clk);
    check("bounce stage", int'(stage), 1);

    // Idle in GOT0 for 60 cycles.
    btn = 3'b000;
    first  = 0;
    hits   = 0;
    stg_at = -1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (seq_err) begin
        hits++;
        if (first == 0) begin
          first  = c;
          stg_at = int'(stage);
        end
      end
    end
`ifdef BTN_SEQ_TIMEOUT_EN
    check("timeout cycle", first, 50);
    check("timeout pulses", hits, 1);
    check("timeout stage", stg_at, 0);
`else
    check("no timeout pulses", hits, 0);
    check("no timeout stage", int'(stage), 1);
`endif

    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int k = 0; k < 15; k++) run_step(k, steps[k]);

    // Reset while in GOT1 with button 2 held.
    check("pre-reset stage", int'(stage), 2);
    btn = 3'b100;
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("in-reset outputs %0d", c), int'(outs), 0);
    end
    rst = 1'b0;
    wait_press(lat);
    check("post-reset latency", lat, 7);
    check("post-reset press_pulse", int'(press_pulse), 4);
    check("post-reset press_code", int'(press_code), 2);
    @(negedge clk);
    check("post-reset seq_err", int'(seq_err), 1);
    check("post-reset seq_ok", int'(seq_ok), 0);
    check("post-reset stage", int'(stage), 0);
    @(negedge clk);
    check("post-reset seq_err one cycle", int'(seq_err), 0);
    btn = 3'b000;
    repeat (10) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
